// File: rtl/sync_fifo_pkg.sv
// Shared constants and elaboration helpers for the single-clock parametrised FIFO.
package sync_fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  function automatic int DEPTH(input int addr_width);
    return 1 << addr_width;
  endfunction

  // af must be reachable (1..DEPTH), ae must leave room to be non-almost-empty (0..DEPTH-1)
  function automatic bit thresh_ok(input int addr_width, input int af, input int ae);
    return (af >= 1) && (af <= DEPTH(addr_width)) &&
           (ae >= 0) && (ae <= DEPTH(addr_width) - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: clocked write port, combinational read port.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  import sync_fifo_pkg::*;

  logic [DEPTH(ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] mem;

  // no reset: contents survive RST, only the pointers are cleared
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky
// overflow/underflow and selectable first-word-fall-through read.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

  if (!thresh_ok(ADDR_WIDTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
    $error("sync_fifo_param: AF_THRESH/AE_THRESH out of range");
  end

  logic [ADDR_WIDTH:0]   wptr, rptr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  wr_en, rd_en;
  fifo_flags_t           flags;

  // flags come straight off the registered count, so they lag the causing edge by one cycle
  assign flags = '{full:         (count == DEPTH_C),
                   empty:        (count == '0),
                   almost_full:  (count >= AF_C),
                   almost_empty: (count <= AE_C)};

  assign full         = flags.full;
  assign empty        = flags.empty;
  assign almost_full  = flags.almost_full;
  assign almost_empty = flags.almost_empty;

  assign wr_en = write & ~full;
  assign rd_en = read  & ~empty;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (write & full)  overflow  <= 1'b1;
      if (read  & empty) underflow <= 1'b1;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (CLK),
    .we    (wr_en),
    .waddr (wptr[ADDR_WIDTH-1:0]),
    .wdata (wdata),
    .raddr (rptr[ADDR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  if (FWFT == FWFT_ON) begin : g_fwft
    // head entry always presented; meaningless while empty
    assign rdata = mem_rdata;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rdata_q;
    always_ff @(posedge CLK) begin
      if (RST)        rdata_q <= '0;
      else if (rd_en) rdata_q <= mem_rdata;
    end
    assign rdata = rdata_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed + randomized check of sync_fifo_param in both read modes against a queue model.
module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AF = 12;
  localparam int AE = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic [DW-1:0] wdata = '0;

  logic [DW-1:0] rdata, rdata_f;
  logic          full, empty, af, ae, ovf, unf;
  logic          full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
  logic [AW:0]   count, count_f;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rdata;
  bit            m_ovf, m_unf;

  always #5 CLK = ~CLK;

  sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut (
    .CLK(CLK), .RST(RST), .write(write), .wdata(wdata), .read(read), .rdata(rdata),
    .full(full), .empty(empty), .almost_full(af), .almost_empty(ae), .count(count),
    .overflow(ovf), .underflow(unf)
  );

  sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut_f (
    .CLK(CLK), .RST(RST), .write(write), .wdata(wdata), .read(read), .rdata(rdata_f),
    .full(full_f), .empty(empty_f), .almost_full(af_f), .almost_empty(ae_f), .count(count_f),
    .overflow(ovf_f), .underflow(unf_f)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count",     32'(count),     32'(n));
    chk("full",      32'(full),      32'(n == DEPTH));
    chk("empty",     32'(empty),     32'(n == 0));
    chk("alm_full",  32'(af),        32'(n >= AF));
    chk("alm_empty", 32'(ae),        32'(n <= AE));
    chk("overflow",  32'(ovf),       32'(m_ovf));
    chk("underflow", 32'(unf),       32'(m_unf));
    chk("rdata",     32'(rdata),     32'(m_rdata));
    chk("f_count",   32'(count_f),   32'(n));
    chk("f_ovf_unf", 32'({ovf_f, unf_f}), 32'({m_ovf, m_unf}));
    if (n != 0) chk("f_rdata", 32'(rdata_f), 32'(q[0]));
  endtask

  // one clock with the given requests; model advances from the pre-edge occupancy
  task automatic cycle(input bit w, input logic [DW-1:0] wd, input bit r);
    bit was_full, was_empty;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    write = w; wdata = wd; read = r;
    @(posedge CLK); #1;
    if (w && was_full)  m_ovf = 1'b1;
    if (r && was_empty) m_unf = 1'b1;
    if (r && !was_empty) m_rdata = q.pop_front();
    if (w && !was_full)  q.push_back(wd);
    write = 1'b0; read = 1'b0;
    check_all();
  endtask

  task automatic do_reset(input bit w, input bit r);
    RST = 1'b1; write = w; read = r; wdata = 8'hEE;
    @(posedge CLK); #1;
    RST = 1'b0; write = 1'b0; read = 1'b0;
    q.delete(); m_rdata = '0; m_ovf = 1'b0; m_unf = 1'b0;
    check_all();
  endtask

  task automatic fill_to(input int n);
    while (q.size() < n) cycle(1'b1, DW'($urandom), 1'b0);
    while (q.size() > n) cycle(1'b0, '0, 1'b1);
  endtask

  initial begin
    q.delete(); m_rdata = '0; m_ovf = 1'b0; m_unf = 1'b0;
    do_reset(1'b0, 1'b0);

    // fill with 0x00..0x0F, then one write too many
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0);
    cycle(1'b1, 8'h77, 1'b0);

    // drain in order
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);

    // read on empty straight after reset
    do_reset(1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b0, '0, 1'b1);

    // fall-through of a single word
    do_reset(1'b0, 1'b0);
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);

    // steady state at 5
    fill_to(5);
    for (int i = 0; i < 20; i++) cycle(1'b1, DW'($urandom), 1'b1);
    fill_to(0);

    // simultaneous at full
    do_reset(1'b0, 1'b0);
    fill_to(DEPTH);
    cycle(1'b1, 8'h99, 1'b1);

    // simultaneous at empty
    do_reset(1'b0, 1'b0);
    cycle(1'b1, 8'h42, 1'b1);
    cycle(1'b0, '0, 1'b1);

    // reset mid-operation with requests pending
    fill_to(9);
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b0, '0, 1'b0);
    fill_to(DEPTH);
    cycle(1'b1, 8'h12, 1'b0);
    fill_to(9);
    do_reset(1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // pointer wrap: paired write/read at random occupancies
    for (int k = 0; k < 40; k++) begin
      fill_to($urandom_range(0, DEPTH));
      cycle(1'b1, DW'($urandom), 1'b1);
    end

    // free-running random traffic
    for (int k = 0; k < 300; k++)
      cycle(1'($urandom), DW'($urandom), 1'($urandom));
    fill_to(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised FIFO for same-domain buffering. Complements the dual-clock FIFO already in the codebase.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, a selectable first-word-fall-through (FWFT) mode, and sticky overflow/underflow error flags.
- Sits between a producer and a consumer in one clock domain, typically in front of a dual-clock FIFO or a packet engine.

Parameters:
DATA_WIDTH, 8, width of each entry in bits
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH
AF_THRESH, 12, almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
CLK  input  1  single clock, all logic on rising edge
RST  input  1  reset, synchronous, active-high
write  input  1  write request
wdata  input  DATA_WIDTH  write data
read  input  1  read request (FWFT=1: acknowledge of the head entry)
rdata  output  DATA_WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty

Behaviour:
- RST is sampled on the CLK edge only. On reset:
  - wptr = rptr = 0, count = 0, rdata = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - overflow = 0, underflow = 0.
  - Memory contents are not cleared.
- Reset asserted mid-operation discards all entries on that edge; requests in the reset cycle are ignored.
- Pointers:
  - wptr and rptr are ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits address the memory.
  - Both wrap naturally modulo 2*DEPTH.
  - count is a registered up/down counter and must always equal wptr - rptr (mod 2*DEPTH).
- wr_en = write & ~full; rd_en = read & ~empty.
  - Both use the flag values registered before the current edge.
- Accepted write: mem[wptr] <= wdata; wptr increments.
- Accepted read: rptr increments.
- count update on each edge:
  - +1 if wr_en only.
  - -1 if rd_en only.
  - unchanged if both or neither.
- All flags are decoded from the registered count and change in the cycle after the causing edge.
- full and empty are mutually exclusive. almost_full and almost_empty may both be high only if AE_THRESH >= AF_THRESH, which is a legal but discouraged configuration.
- Boundary cases:
  - Full with write & read: read accepted, write dropped, overflow sets. Count goes DEPTH -> DEPTH-1.
  - Empty with write & read: write accepted, read dropped, underflow sets. Count goes 0 -> 1.
  - Write while full: data discarded, wptr held, overflow <= 1 until RST.
  - Read while empty: rptr held, rdata held, underflow <= 1 until RST.
- FWFT=0 (standard mode):
  - rdata <= mem[rptr] on an accepted read, so data is valid in the cycle after read.
  - rdata holds otherwise.
  - Write-to-empty-deassert latency is 1 cycle.
- FWFT=1 (first-word-fall-through):
  - rdata = mem[rptr] combinationally whenever empty = 0; rdata is undefined when empty = 1.
  - read pops the head, and the next entry appears in the same cycle as the pointer update.
  - A word written into an empty FIFO is visible on rdata 1 cycle after the write edge, together with empty deasserting.
- Memory: register array with write on CLK and asynchronous read. Read-before-write at the same address cannot occur because full blocks writes.

Decomposition:
- Package sync_fifo_pkg:
  - depth function DEPTH(ADDR_WIDTH).
  - Mode constants FWFT_OFF = 0, FWFT_ON = 1.
  - Threshold legality check function, used by an elaboration assertion.
- One sub-module, sync_fifo_mem: DEPTH x DATA_WIDTH register array with a registered write port and a combinational read port.
- Pointer, count and flag logic stay in the top level.

Test Plan:
- Reset, then 16 writes of 0x00..0x0F with no reads (defaults):
  - full rises on the cycle after the 16th write; count = 16.
  - almost_full rises after the 12th write.
  - A 17th write sets overflow; count stays 16.
- From full, 16 reads (FWFT=0): rdata sequence 0x00..0x0F, each one cycle after its read; empty rises after the last read; almost_empty rises once count = 2.
- FWFT=1, write 0xA5 into empty: next cycle empty = 0 and rdata = 0xA5 with no read issued; a read then gives empty = 1.
- Simultaneous write & read:
  - At count = 5 for 20 cycles: count stays 5 and data order is preserved.
  - At full: count goes 16 -> 15 and overflow = 1.
  - At empty: count goes 0 -> 1 and underflow = 1.
- Read on empty after reset: underflow = 1, rdata stays 0x00, rptr unchanged. RST asserted at count = 9 clears count, underflow and overflow on that edge.
- Wrap: 40 write/read pairs at a random occupancy of 0..16; a scoreboard matches every word and count always equals wptr - rptr.
